i2c_slave_rx: RTL and testbench
===============================

# i2c_slave_rx

Write-only I2C target (slave) receiver; the responder end of the team's I2C master.
- Watches the open-drain SCL/SDA lines and detects START/STOP.
- Matches the 7-bit address against `own_addr`, ACKs, and delivers each received data byte with a one-cycle valid strobe.
- Sits on the same `dut_if` bus nets as the master and drives SDA only through an output-enable (pull-low) port.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `scl_i`/`sda_i` before edge detection (legal 2..3).

Ports:
- `clk`  input  1: system clock, 100 MHz.
- `rst_n`  input  1: asynchronous, active-low reset; single clock domain.
- `own_addr`  input  7: this target's address; held static while `busy` is high.
- `scl_i`  input  1: SCL line value (asynchronous).
- `sda_i`  input  1: SDA line value (asynchronous).
- `sda_oe`  output  1: 1 means pull SDA low; the pad ties the output to 0 when enabled.
- `data_out`  output  8: last received data byte, MSB first on the wire.
- `data_valid`  output  1: one-cycle strobe; `data_out` is new this cycle.
- `addr_match`  output  1: high from the address ACK until STOP or repeated START.
- `busy`  output  1: high between START and STOP.
- `stop_det`  output  1: one-cycle strobe on STOP.

## Operation
Bus conditions:
- Synchronized SCL/SDA produce SCL rise and fall events.
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- SDA is sampled on each SCL rise.

State machine (enum in package):
- IDLE: `sda_oe`=0. START → ADDR, bit counter=0.
- ADDR: shift 8 bits (7 address bits, then R/W).
  - After the 8th SCL rise, wait for the next SCL fall.
  - If addr==`own_addr` and R/W=0: assert `sda_oe`, set `addr_match`, go to ADDR_ACK.
  - Otherwise: go to IGNORE with SDA released. This gives a NACK; read requests are unsupported.
- ADDR_ACK: hold `sda_oe`=1 through the ACK clock. On the ACK SCL fall, release and go to DATA.
- DATA: shift 8 bits. On the SCL fall after the 8th bit:
  - load `data_out`, pulse `data_valid`;
  - assert `sda_oe` and go to DATA_ACK.
- DATA_ACK: on the ACK SCL fall, release and return to DATA with counter=0.
- IGNORE: release SDA; wait for STOP or START.

Events valid in any non-IDLE state:
- STOP: go to IDLE; clear `busy` and `addr_match`; pulse `stop_det`; discard any partial byte; `sda_oe`=0 next cycle.
- Repeated START: go to ADDR; clear the counter and `addr_match`; discard any partial byte.
- START and STOP detection take priority over SCL edge processing in the same cycle.
- Other rules:
  - The bit counter is 4 bits and saturates at 8; it never wraps.
  - `data_out` holds its value until the next completed byte.

## Timing
- Reset values, applied asynchronously: `sda_oe`=0, `data_out`=0x00, `data_valid`=0, `addr_match`=0, `busy`=0, `stop_det`=0, state=IDLE.
- Reset asserted mid-transfer releases SDA immediately, with no clock edge needed.
- Pin-to-event latency is `SYNC_STAGES`+1 cycles: 3 cycles at default.
- `sda_oe` rises or falls 1 cycle after the detected SCL fall, i.e. `SYNC_STAGES`+2 cycles after the pin edge.
- `data_valid` pulses in the same cycle that `sda_oe` rises for the data ACK.
- `stop_det` and the `busy` deassert take effect 1 cycle after STOP detection.
- Bus requirements: SCL high ≥ 6 clk, SCL low ≥ 6 clk, SDA setup/hold around SCL ≥ 4 clk.
  - Shorter phases are out of spec; behaviour is undefined but the state machine must not lock up.
- `busy` rises 1 cycle after START detection.

## Structure
- Package `i2c_pkg`:
  - constants `I2C_ADDR_W`=7 and `I2C_DATA_W`=8;
  - state enum `i2c_rx_state_e` (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - `I2C_RW_WRITE`=1'b0.
- Sub-module `i2c_bus_cond`: synchronizers plus edge detection. Outputs single-cycle `scl_rise`, `scl_fall`, `start_det`, `stop_det_raw`, and synced `sda_s`.
- The top holds the FSM, shift register, bit counter and output registers.

## Test plan
- Write of 0x5A to addr 0x2C with `own_addr`=0x2C:
  - ACK driven low on the 9th clock after the address and after the data byte;
  - `data_valid` pulses once with `data_out`=0x5A;
  - `stop_det` pulses; `busy` returns to 0.
- Address 0x2D with `own_addr`=0x2C:
  - `sda_oe` never asserts and `data_valid` never pulses;
  - `addr_match`=0 throughout;
  - IGNORE state until STOP.
- Read request (addr 0x2C, R/W=1): NACK (SDA stays high), then IGNORE; no `data_valid`.
- Burst of 0x01, 0xFF, 0x80 in one transfer: three `data_valid` pulses carrying those values in order, and three data ACKs.
- Repeated START after 4 data bits, then a write of 0xA5 to 0x2C:
  - the partial byte is discarded;
  - exactly one `data_valid` with 0xA5.
- Reset edge cases:
  - `rst_n` low during the data ACK: `sda_oe` drops to 0 with no clock, and all outputs return to reset values.
  - STOP after 3 data bits: the partial byte is discarded, with no `data_valid`.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C target receiver.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic       I2C_RW_WRITE = 1'b0;
    localparam logic [3:0] BIT_CNT_MAX  = 4'd8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_rx_state_e;

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronizes the raw SCL/SDA lines and turns them into single-cycle bus events.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det_raw,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_now;
    logic                   sda_now;
    logic                   scl_p1;
    logic                   sda_p1;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Synchronizers reset to the idle-bus level so reset release never fakes a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync     <= '1;
            sda_sync     <= '1;
            scl_p1       <= 1'b1;
            sda_p1       <= 1'b1;
            scl_rise     <= 1'b0;
            scl_fall     <= 1'b0;
            start_det    <= 1'b0;
            stop_det_raw <= 1'b0;
            sda_s        <= 1'b1;
        end else begin
            scl_sync     <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync     <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            // Edge stage: events and sda_s are registered together so they stay aligned.
            scl_p1       <= scl_now;
            sda_p1       <= sda_now;
            scl_rise     <= scl_now & ~scl_p1;
            scl_fall     <= ~scl_now & scl_p1;
            start_det    <= scl_now & scl_p1 & sda_p1 & ~sda_now;
            stop_det_raw <= scl_now & scl_p1 & ~sda_p1 & sda_now;
            sda_s        <= sda_now;
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: address match, ACK generation and byte delivery.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [I2C_DATA_W-1:0] data_out,
    output logic                  data_valid,
    output logic                  addr_match,
    output logic                  busy,
    output logic                  stop_det
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det_raw;
    logic sda_s;

    i2c_rx_state_e         state, state_n;
    logic [3:0]            bit_cnt, cnt_n;
    logic [I2C_DATA_W-1:0] shift_q, shift_n;
    logic [I2C_DATA_W-1:0] data_n;
    logic                  valid_n;
    logic                  match_n;
    logic                  busy_n;
    logic                  stop_n;
    logic                  oe_n;

    i2c_bus_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_cond (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det_raw (stop_det_raw),
        .sda_s        (sda_s)
    );

    function automatic logic [3:0] cnt_sat_inc(input logic [3:0] c);
        return (c >= BIT_CNT_MAX) ? BIT_CNT_MAX : c + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            shift_q    <= shift_n;
            data_out   <= data_n;
            data_valid <= valid_n;
            addr_match <= match_n;
            busy       <= busy_n;
            stop_det   <= stop_n;
            sda_oe     <= oe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift_q;
        data_n  = data_out;
        valid_n = 1'b0;
        match_n = addr_match;
        busy_n  = busy;
        stop_n  = 1'b0;
        oe_n    = sda_oe;

        // Bus conditions override any SCL edge seen in the same cycle.
        if (stop_det_raw && state != IDLE) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            match_n = 1'b0;
            busy_n  = 1'b0;
            stop_n  = 1'b1;
            oe_n    = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            match_n = 1'b0;
            busy_n  = 1'b1;
            oe_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    oe_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        if (bit_cnt < BIT_CNT_MAX) shift_n = {shift_q[I2C_DATA_W-2:0], sda_s};
                        cnt_n = cnt_sat_inc(bit_cnt);
                    end else if (scl_fall && bit_cnt == BIT_CNT_MAX) begin
                        cnt_n = 4'd0;
                        if (shift_q[I2C_DATA_W-1:1] == own_addr && shift_q[0] == I2C_RW_WRITE) begin
                            oe_n    = 1'b1;
                            match_n = 1'b1;
                            state_n = ADDR_ACK;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        if (bit_cnt < BIT_CNT_MAX) shift_n = {shift_q[I2C_DATA_W-2:0], sda_s};
                        cnt_n = cnt_sat_inc(bit_cnt);
                    end else if (scl_fall && bit_cnt == BIT_CNT_MAX) begin
                        data_n  = shift_q;
                        valid_n = 1'b1;
                        oe_n    = 1'b1;
                        state_n = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = DATA;
                    end
                end
                IGNORE: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: open-drain bus model, byte scoreboard and bus-level checks.
module tb_i2c_slave_rx;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] own_addr = 7'h2C;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addr_match;
    logic       busy;
    logic       stop_det;

    int compared   = 0;
    int mismatched = 0;
    int valid_cnt  = 0;
    int stop_cnt   = 0;
    int oe_cnt     = 0;
    int match_cnt  = 0;
    logic [7:0] exp_q[$];

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_rx #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .own_addr   (own_addr),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_match (addr_match),
        .busy       (busy),
        .stop_det   (stop_det)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every data_valid pops the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sda_oe) oe_cnt++;
            if (addr_match) match_cnt++;
            if (stop_det) stop_cnt++;
            if (data_valid) begin
                valid_cnt++;
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; tick(10);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(5);
        sda_m = 1'b0; tick(5);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(5);
        scl_m = 1'b1; tick(5);
        sda_m = 1'b1; tick(10);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(5);
        scl_m = 1'b1; tick(10);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(5);
        ack = sda_line; tick(5);
        scl_m = 1'b0; tick(5);
    endtask

    logic ack;
    int   v0, s0, o0, m0;

    initial begin
        // Reset state
        tick(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_match", 32'(addr_match), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Write 0x5A to 0x2C
        v0 = valid_cnt; s0 = stop_cnt;
        i2c_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        send_byte(8'h58, ack);
        check("t1_addr_ack", 32'(ack), 32'd0);
        check("t1_addr_match", 32'(addr_match), 32'd1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, ack);
        check("t1_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        check("t1_busy_after_stop", 32'(busy), 32'd0);
        check("t1_addr_match_after_stop", 32'(addr_match), 32'd0);
        check("t1_stop_pulses", 32'(stop_cnt - s0), 32'd1);
        check("t1_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("t1_data_out_held", 32'(data_out), 32'h5A);

        // Wrong address 0x2D
        v0 = valid_cnt; o0 = oe_cnt; m0 = match_cnt;
        i2c_start();
        send_byte(8'h5A, ack);
        check("t2_addr_nack", 32'(ack), 32'd1);
        check("t2_state_ignore", 32'(dut.state), 32'(IGNORE));
        send_byte(8'h33, ack);
        check("t2_data_nack", 32'(ack), 32'd1);
        check("t2_still_ignore", 32'(dut.state), 32'(IGNORE));
        i2c_stop();
        check("t2_no_oe", 32'(oe_cnt - o0), 32'd0);
        check("t2_no_match", 32'(match_cnt - m0), 32'd0);
        check("t2_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t2_idle_after_stop", 32'(dut.state), 32'(IDLE));

        // Read request to 0x2C
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h59, ack);
        check("t3_read_nack", 32'(ack), 32'd1);
        check("t3_state_ignore", 32'(dut.state), 32'(IGNORE));
        send_byte(8'h77, ack);
        i2c_stop();
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Burst 0x01, 0xFF, 0x80
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h58, ack);
        check("t4_addr_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'h01);
        send_byte(8'h01, ack);
        check("t4_ack_01", 32'(ack), 32'd0);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, ack);
        check("t4_ack_ff", 32'(ack), 32'd0);
        exp_q.push_back(8'h80);
        send_byte(8'h80, ack);
        check("t4_ack_80", 32'(ack), 32'd0);
        i2c_stop();
        check("t4_valid_pulses", 32'(valid_cnt - v0), 32'd3);

        // Repeated START after 4 data bits, then 0xA5
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h58, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_rep_start();
        check("t5_match_cleared", 32'(addr_match), 32'd0);
        check("t5_busy_kept", 32'(busy), 32'd1);
        send_byte(8'h58, ack);
        check("t5_addr_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        check("t5_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        check("t5_valid_pulses", 32'(valid_cnt - v0), 32'd1);

        // STOP after 3 data bits
        v0 = valid_cnt; s0 = stop_cnt;
        i2c_start();
        send_byte(8'h58, ack);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("t6_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t6_stop_pulse", 32'(stop_cnt - s0), 32'd1);
        check("t6_data_out_held", 32'(data_out), 32'hA5);
        check("t6_busy", 32'(busy), 32'd0);

        // Reset during the data ACK
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h58, ack);
        exp_q.push_back(8'h3C);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h3C >> i));
        sda_m = 1'b1; tick(8);
        check("t7_oe_in_ack", 32'(sda_oe), 32'd1);
        check("t7_valid_before_rst", 32'(valid_cnt - v0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_oe_async", 32'(sda_oe), 32'd0);
        check("t7_busy_async", 32'(busy), 32'd0);
        check("t7_match_async", 32'(addr_match), 32'd0);
        check("t7_data_out_async", 32'(data_out), 32'h00);
        check("t7_valid_async", 32'(data_valid), 32'd0);
        tick(2);
        scl_m = 1'b1; tick(5);
        rst_n = 1'b1; tick(10);
        check("t7_state_idle", 32'(dut.state), 32'(IDLE));

        // Transfer after reset recovery
        i2c_start();
        send_byte(8'h58, ack);
        check("t8_addr_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, ack);
        check("t8_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        check("t8_data_out", 32'(data_out), 32'hC3);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
